// File: rtl/prefetch_pkg.sv
// Shared opcodes and interrupt vector arithmetic for the instruction prefetch queue.
package prefetch_pkg;

  localparam int OP_JZ   = 5;
  localparam int OP_JMP  = 6;
  localparam int OP_CALL = 7;
  localparam int OP_RET  = 8;

  // Caller truncates to the address width, which gives the mod 2^MINSTW wrap.
  function automatic int unsigned itr_vector(int unsigned base, int unsigned step, int unsigned idx);
    return base + idx * step;
  endfunction

endpackage

// File: rtl/prefetch_queue_if.sv
// ROM, decode, instruction-stack and interrupt signals of the prefetch queue.
interface prefetch_queue_if #(
  parameter int MINSTW = 8,
  parameter int NBOPCO = 7,
  parameter int NBOPER = 9,
  parameter int NITR   = 1
);
  logic [MINSTW-1:0]        instr_addr;
  logic                     instr_rd;
  logic [NBOPCO+NBOPER-1:0] instr;
  logic                     out_valid;
  logic                     out_ready;
  logic [NBOPCO-1:0]        opcode;
  logic [NBOPER-1:0]        operand;
  logic [MINSTW-1:0]        pc;
  logic                     acc_is_zero;
  logic [MINSTW-1:0]        ret_addr;
  logic                     isp_push;
  logic                     isp_pop;
  logic [MINSTW-1:0]        isp_addr;
  logic [NITR-1:0]          itr;
  logic [NITR-1:0]          itr_ack;

  modport master (
    output instr_addr, instr_rd, out_valid, opcode, operand, pc, isp_push, isp_pop, isp_addr, itr_ack,
    input  instr, out_ready, acc_is_zero, ret_addr, itr
  );
  modport slave (
    input  instr_addr, instr_rd, out_valid, opcode, operand, pc, isp_push, isp_pop, isp_addr, itr_ack,
    output instr, out_ready, acc_is_zero, ret_addr, itr
  );
endinterface

// File: rtl/prefetch_fifo.sv
// DEPTH-entry circular buffer (DEPTH a power of 2) with push, pop and synchronous clear.
module prefetch_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_clear,
  input  logic [W-1:0]           i_data,
  output logic [W-1:0]           o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rp];
  assign o_count = r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push & ~i_clear) r_mem[r_wp] <= i_data;
  end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetch control, epoch-tagged read drop, decode redirect, interrupt entry.
// Build option PREFETCH_STATIC_JMP_EN: JMP/CALL redirect fetch when the word arrives from ROM.
module prefetch_queue
  import prefetch_pkg::*;
#(
  parameter int MINSTW  = 8,
  parameter int NBOPCO  = 7,
  parameter int NBOPER  = 9,
  parameter int DEPTH   = 4,
  parameter int NITR    = 1,
  parameter int ITRADD  = 0,
  parameter int ITRSTEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  prefetch_queue_if.master bus
);
  localparam int IW = NBOPCO + NBOPER;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [MINSTW-1:0] addr;
    logic [IW-1:0]     instr;
  } entry_t;

  logic              r_run, r_infl, r_infl_ep, r_epoch;
  logic [MINSTW-1:0] r_fpc, r_rd_addr;
  entry_t            w_head, w_wdata;
  logic [CW-1:0]     w_count;
  logic              w_full, w_empty;
  logic              w_rd, w_wr, w_take, w_cons, w_redir, w_static, w_jmp_at_cons;
  logic [MINSTW-1:0] w_target, w_vec;
  logic [NITR-1:0]   w_ack;
  logic [NBOPCO-1:0] w_op;

  prefetch_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_wr),
    .i_pop   (w_cons),
    .i_clear (w_redir),
    .i_data  (w_wdata),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // count + inflight < DEPTH, written without an adder
  assign w_rd    = r_run & ~w_full & ~(r_infl & (w_count == CW'(DEPTH - 1)));
  assign w_wr    = r_infl & (r_infl_ep == r_epoch) & ~w_redir;
  assign w_wdata = '{addr: r_rd_addr, instr: bus.instr};
  assign w_op    = w_head.instr[IW-1:NBOPER];

`ifdef PREFETCH_STATIC_JMP_EN
  logic [NBOPCO-1:0] w_wop;
  assign w_wop         = bus.instr[IW-1:NBOPER];
  assign w_static      = w_wr & ((w_wop == NBOPCO'(OP_JMP)) | (w_wop == NBOPCO'(OP_CALL)));
  assign w_jmp_at_cons = 1'b0;
`else
  assign w_static      = 1'b0;
  assign w_jmp_at_cons = 1'b1;
`endif

  // Lowest-index channel wins: scan downward so the last hit is the lowest.
  always_comb begin
    w_ack = '0;
    w_vec = '0;
    for (int i = NITR - 1; i >= 0; i--) begin
      if (bus.itr[i]) begin
        w_ack = NITR'(1) << i;
        w_vec = MINSTW'(itr_vector(ITRADD, ITRSTEP, i));
      end
    end
  end

  assign w_take        = ~w_empty & (|bus.itr);
  assign bus.out_valid = ~w_empty & ~w_take;
  assign w_cons        = bus.out_valid & bus.out_ready;

  always_comb begin
    w_redir  = 1'b0;
    w_target = w_head.instr[MINSTW-1:0];
    if (w_take) begin
      w_redir  = 1'b1;
      w_target = w_vec;
    end else if (w_cons) begin
      if (w_op == NBOPCO'(OP_JZ))
        w_redir = bus.acc_is_zero;
      else if ((w_op == NBOPCO'(OP_JMP)) | (w_op == NBOPCO'(OP_CALL)))
        w_redir = w_jmp_at_cons;
      else if (w_op == NBOPCO'(OP_RET)) begin
        w_redir  = 1'b1;
        w_target = bus.ret_addr;
      end
    end
  end

  assign bus.instr_rd   = w_rd;
  assign bus.instr_addr = r_fpc;
  assign bus.opcode     = w_op;
  assign bus.operand    = w_head.instr[NBOPER-1:0];
  assign bus.pc         = w_head.addr;
  assign bus.isp_push   = w_take | (w_cons & (w_op == NBOPCO'(OP_CALL)));
  assign bus.isp_pop    = w_cons & (w_op == NBOPCO'(OP_RET));
  assign bus.isp_addr   = w_take ? w_head.addr : w_head.addr + MINSTW'(1);
  assign bus.itr_ack    = w_take ? w_ack : '0;

  // A read issued in a redirect cycle carries the old epoch and is dropped on arrival.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run     <= 1'b0;
      r_fpc     <= '0;
      r_rd_addr <= '0;
      r_infl    <= 1'b0;
      r_infl_ep <= 1'b0;
      r_epoch   <= 1'b0;
    end else begin
      r_run  <= 1'b1;
      r_infl <= w_rd;
      if (w_rd) begin
        r_rd_addr <= r_fpc;
        r_infl_ep <= r_epoch;
      end
      if (w_redir) begin
        r_fpc   <= w_target;
        r_epoch <= ~r_epoch;
      end else if (w_static) begin
        r_fpc   <= w_wdata.instr[MINSTW-1:0];
        r_epoch <= ~r_epoch;
      end else if (w_rd) begin
        r_fpc <= r_fpc + MINSTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
// Randomized bench for prefetch_queue against a queue-based reference model of fetch/consume/redirect.
module tb_prefetch_queue;
  localparam int MINSTW  = 8;
  localparam int NBOPCO  = 7;
  localparam int NBOPER  = 9;
  localparam int DEPTH   = 4;
  localparam int NITR    = 2;
  localparam int ITRADD  = 'h30;
  localparam int ITRSTEP = 4;
  localparam int IW      = NBOPCO + NBOPER;
`ifdef PREFETCH_STATIC_JMP_EN
  localparam bit STATIC = 1'b1;
`else
  localparam bit STATIC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  prefetch_queue_if #(.MINSTW(MINSTW), .NBOPCO(NBOPCO), .NBOPER(NBOPER), .NITR(NITR)) bus ();

  prefetch_queue #(
    .MINSTW(MINSTW), .NBOPCO(NBOPCO), .NBOPER(NBOPER), .DEPTH(DEPTH),
    .NITR(NITR), .ITRADD(ITRADD), .ITRSTEP(ITRSTEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [IW-1:0] rom [256];
  logic [IW-1:0] rom_q = '0;
  always @(posedge clk) if (bus.instr_rd) rom_q <= rom[bus.instr_addr];
  assign bus.instr = rom_q;

  typedef struct {
    int addr;
    int ins;
  } ent_t;

  ent_t q[$];
  int   fpc, paddr;
  bit   run, pv, pstale;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    fpc = 0; run = 1'b0; pv = 1'b0; pstale = 1'b0; paddr = 0;
  endtask

  task automatic load_rom(input int mode);
    for (int a = 0; a < 256; a++) begin
      int r, o;
      if (mode == 0) begin
        rom[a] = IW'(a % 512);
      end else begin
        r = $urandom_range(9);
        if (r <= 4)      o = $urandom_range(4);
        else if (r <= 8) o = r;
        else             o = $urandom_range(127, 9);
        rom[a] = {NBOPCO'(o), NBOPER'($urandom_range(511))};
      end
    end
  endtask

  // Checks one cycle's outputs, then advances the model across the coming rising edge.
  task automatic step();
    int  op, opr, tgt, ch, hpc, iop, ins;
    bit  hv, take, ov, cons, redir, rd, epush, epop, npv, npst;
    ent_t e;
    #1;
    op = 0; opr = 0; hpc = 0;
    rd   = run && ((q.size() + int'(pv)) < DEPTH);
    hv   = q.size() != 0;
    take = hv && (bus.itr != '0);
    ov   = hv && !take;
    if (hv) begin
      op  = q[0].ins >> NBOPER;
      opr = q[0].ins % (1 << NBOPER);
      hpc = q[0].addr;
    end
    cons = ov && bus.out_ready;
    ch   = bus.itr[0] ? 0 : 1;
    redir = 1'b0; tgt = 0;
    if (take) begin
      redir = 1'b1; tgt = (ITRADD + ch * ITRSTEP) % 256;
    end else if (cons) begin
      if (op == 5 && bus.acc_is_zero) begin redir = 1'b1; tgt = opr % 256; end
      else if ((op == 6 || op == 7) && !STATIC) begin redir = 1'b1; tgt = opr % 256; end
      else if (op == 8) begin redir = 1'b1; tgt = int'(bus.ret_addr); end
    end
    epush = take || (cons && op == 7);
    epop  = cons && op == 8;

    chk("instr_rd", 32'(bus.instr_rd), 32'(rd));
    if (rd) chk("instr_addr", 32'(bus.instr_addr), 32'(fpc));
    chk("out_valid", 32'(bus.out_valid), 32'(ov));
    if (ov) begin
      chk("pc", 32'(bus.pc), 32'(hpc));
      chk("head_instr", 32'({bus.opcode, bus.operand}), 32'(q[0].ins));
    end
    chk("isp_push", 32'(bus.isp_push), 32'(epush));
    chk("isp_pop", 32'(bus.isp_pop), 32'(epop));
    if (epush) chk("isp_addr", 32'(bus.isp_addr), 32'(take ? hpc : (hpc + 1) % 256));
    chk("itr_ack", 32'(bus.itr_ack), take ? 32'(1 << ch) : 32'(0));

    npv = rd; npst = 1'b0;
    if (redir) begin
      q.delete();
      npst = 1'b1;
      paddr = fpc;
      fpc = tgt;
    end else begin
      if (cons) void'(q.pop_front());
      if (pv && !pstale) begin
        ins = int'(rom[paddr[7:0]]);
        e.addr = paddr; e.ins = ins;
        q.push_back(e);
      end else begin
        ins = 0;
      end
      iop = ins >> NBOPER;
      paddr = fpc;
      if (rd) fpc = (fpc + 1) % 256;
      if (STATIC && pv && !pstale && (iop == 6 || iop == 7)) begin
        fpc = (ins % (1 << NBOPER)) % 256;
        npst = 1'b1;
      end
    end
    pv = npv; pstale = npst; run = 1'b1;
  endtask

  task automatic run_phase(input int n, input int rdy_pct, input int itr_pct);
    repeat (n) begin
      bus.out_ready   = ($urandom_range(99) < rdy_pct);
      bus.itr         = ($urandom_range(99) < itr_pct) ? NITR'($urandom_range(3)) : '0;
      bus.acc_is_zero = $urandom_range(1) != 0;
      bus.ret_addr    = MINSTW'($urandom_range(255));
      step();
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input int mode);
    rst = 1'b0;
    #1;
    chk("rst_instr_rd", 32'(bus.instr_rd), 32'(0));
    chk("rst_instr_addr", 32'(bus.instr_addr), 32'(0));
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_isp_push", 32'(bus.isp_push), 32'(0));
    chk("rst_isp_pop", 32'(bus.isp_pop), 32'(0));
    chk("rst_itr_ack", 32'(bus.itr_ack), 32'(0));
    load_rom(mode);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus.out_ready = 1'b0; bus.itr = '0; bus.acc_is_zero = 1'b0; bus.ret_addr = '0;
    do_reset(0);
    run_phase(30, 100, 0);
    run_phase(20, 0, 0);
    run_phase(20, 100, 0);
    run_phase(40, 60, 10);
    do_reset(1);
    run_phase(2000, 70, 5);
    do_reset(1);
    run_phase(2000, 40, 15);
    run_phase(500, 100, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
